// File: rtl/commit_fence_sequencer_if.sv
// Request/commit handshake between the commit stage (master) and the fence sequencer (slave).
// Signal suffixes are written from the sequencer's point of view.
interface commit_fence_sequencer_if;
    logic       req_valid_i;
    logic [1:0] req_op_i;
    logic       req_ready_o;
    logic       done_o;
    logic [1:0] done_op_o;

    modport slave (
        input  req_valid_i,
        input  req_op_i,
        output req_ready_o,
        output done_o,
        output done_op_o
    );

    modport master (
        output req_valid_i,
        output req_op_i,
        input  req_ready_o,
        input  done_o,
        input  done_op_o
    );
endinterface

// File: rtl/commit_fence_sequencer.sv
// Sequences FENCE / FENCE.I / SFENCE.VMA / D$-flush retirements: drain the store buffer,
// then D$, I$ and TLB flush handshakes, then a one-cycle commit acknowledge.
module commit_fence_sequencer #(
    parameter int DRAIN_TIMEOUT = 1024,
    parameter int CNT_W         = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    commit_fence_sequencer_if.slave    cmt,
    input  logic                       halt_i,
    input  logic                       no_st_pending_i,
    output logic                       dcache_flush_o,
    input  logic                       dcache_flush_ack_i,
    output logic                       icache_flush_o,
    input  logic                       icache_flush_ack_i,
    output logic                       tlb_flush_o,
    output logic                       busy_o,
    output logic                       timeout_o,
    output logic [CNT_W-1:0]           busy_cycles_o
);

    localparam logic [1:0] OP_FENCE        = 2'd0;
    localparam logic [1:0] OP_FENCE_I      = 2'd1;
    localparam logic [1:0] OP_SFENCE_VMA   = 2'd2;
    localparam logic [1:0] OP_FLUSH_DCACHE = 2'd3;

    localparam int              DCNT_W    = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [DCNT_W-1:0] DRAIN_MAX = DCNT_W'(DRAIN_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_DFLUSH,
        S_IFLUSH,
        S_TLB,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [DCNT_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   busy_cnt_q, busy_cnt_d;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        drain_cnt_d     = drain_cnt_q;
        timeout_d       = timeout_q;
        cmt.req_ready_o = 1'b0;
        cmt.done_o      = 1'b0;
        cmt.done_op_o   = 2'd0;
        dcache_flush_o  = 1'b0;
        icache_flush_o  = 1'b0;
        tlb_flush_o     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cmt.req_ready_o = !halt_i;
                if (cmt.req_valid_i && !halt_i) begin
                    op_d        = cmt.req_op_i;
                    drain_cnt_d = '0;
                    state_d     = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (no_st_pending_i) begin
                    state_d = (op_q == OP_SFENCE_VMA) ? S_TLB : S_DFLUSH;
                end else begin
                    if (drain_cnt_q != DRAIN_MAX) begin
                        drain_cnt_d = drain_cnt_q + DCNT_W'(1);
                    end
                    // Sticky debug flag; the sequence keeps waiting for the drain.
                    if (drain_cnt_d == DRAIN_MAX) begin
                        timeout_d = 1'b1;
                    end
                end
            end
            S_DFLUSH: begin
                dcache_flush_o = 1'b1;
                if (dcache_flush_ack_i) begin
                    state_d = (op_q == OP_FENCE_I) ? S_IFLUSH : S_DONE;
                end
            end
            S_IFLUSH: begin
                icache_flush_o = 1'b1;
                if (icache_flush_ack_i) begin
                    state_d = S_DONE;
                end
            end
            S_TLB: begin
                tlb_flush_o = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                cmt.done_o    = 1'b1;
                cmt.done_op_o = op_q;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o        = (state_q != S_IDLE);
    assign timeout_o     = timeout_q;
    assign busy_cycles_o = busy_cnt_q;

    always_comb begin
        busy_cnt_d = busy_cnt_q;
        if (busy_o && (busy_cnt_q != '1)) begin
            busy_cnt_d = busy_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            op_q        <= OP_FENCE;
            drain_cnt_q <= '0;
            timeout_q   <= 1'b0;
            busy_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            drain_cnt_q <= drain_cnt_d;
            timeout_q   <= timeout_d;
            busy_cnt_q  <= busy_cnt_d;
        end
    end

    logic unused_op;
    assign unused_op = (OP_FLUSH_DCACHE == OP_FENCE);

endmodule

// File: doc/commit_fence_sequencer.md
Name: commit_fence_sequencer

Overview:
Sequences the multi-cycle fence-class operations that retire from port 0 of the commit stage: FENCE, FENCE.I, SFENCE.VMA and external D$ flush requests. The commit stage hands it one request at a time. The block waits for the store buffer to drain, then drives the D$, I$ and TLB flush handshakes in the required order. It pulses a completion strobe that the commit stage uses as its commit acknowledgement. It also provides a sticky drain-timeout flag and a saturating busy-cycle counter for debug and performance.

Parameters:
DRAIN_TIMEOUT, 1024, cycles spent in DRAIN before timeout_o is set (must be >= 1)
CNT_W, 32, width of busy_cycles_o

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
halt_i  in  1  halt request; blocks acceptance of new requests only
req_valid_i  in  1  fence-class request valid
req_op_i  in  2  0=FENCE, 1=FENCE_I, 2=SFENCE_VMA, 3=FLUSH_DCACHE
req_ready_o  out  1  request accepted when req_valid_i && req_ready_o
no_st_pending_i  in  1  store buffer empty
dcache_flush_o  out  1  D$ flush request (level)
dcache_flush_ack_i  in  1  D$ flush complete
icache_flush_o  out  1  I$ flush request (level)
icache_flush_ack_i  in  1  I$ flush complete
tlb_flush_o  out  1  TLB flush, single-cycle pulse
busy_o  out  1  sequence in progress
done_o  out  1  single-cycle completion pulse
done_op_o  out  2  op code of the completed request, valid with done_o
timeout_o  out  1  sticky; drain exceeded DRAIN_TIMEOUT
busy_cycles_o  out  CNT_W  saturating count of cycles with busy_o=1

Behaviour:
- Reset (rst_i sampled high): state=IDLE. All outputs are 0 except req_ready_o, which is 1 if halt_i=0. Latched op, drain counter and busy_cycles_o are cleared. A reset mid-sequence abandons the sequence with no done_o.
- States: IDLE, DRAIN, DFLUSH, IFLUSH, TLB, DONE.
- IDLE: req_ready_o = !halt_i (combinational). On acceptance, latch req_op_i, clear the drain counter, go to DRAIN.
- DRAIN:
  - If no_st_pending_i=1 this cycle, the next state is chosen by op: FENCE->DFLUSH, FENCE_I->DFLUSH, FLUSH_DCACHE->DFLUSH, SFENCE_VMA->TLB.
  - Otherwise increment the drain counter, which saturates at DRAIN_TIMEOUT.
  - When the counter equals DRAIN_TIMEOUT, set timeout_o to 1. It stays 1 until reset. The block keeps waiting; there is no abort.
- DFLUSH: dcache_flush_o=1 for the whole state.
  - dcache_flush_ack_i=1 in any DFLUSH cycle, including the first, ends the state.
  - Next state: FENCE_I->IFLUSH, otherwise DONE.
- IFLUSH: icache_flush_o=1. icache_flush_ack_i=1 in any IFLUSH cycle ends the state; next state DONE.
- TLB: tlb_flush_o=1 for exactly one cycle; next state DONE.
- DONE: done_o=1 and done_op_o=latched op for one cycle; next state IDLE. req_ready_o=0 in DONE, so back-to-back requests are separated by at least one IDLE cycle.
- Acks arriving outside their matching state are ignored and are not remembered.
- busy_o = (state != IDLE).
- busy_cycles_o increments every cycle busy_o=1 and saturates at all-ones.
- halt_i asserted mid-sequence has no effect on the in-flight sequence.
- Minimum latency, with acceptance in cycle T, drain already true and same-cycle acks:
  - FENCE / FLUSH_DCACHE / SFENCE_VMA: done_o in T+3.
  - FENCE_I: done_o in T+4.
- Outputs are registered-state decodes only; there is no combinational path from ack inputs to flush outputs.
- req_ready_o depends combinationally on halt_i.

Test Plan:
- FENCE, no_st_pending_i=1, dcache_flush_ack_i tied 1, request accepted in cycle 0 -> dcache_flush_o=1 in cycle 2 only; done_o=1 with done_op_o=0 in cycle 3; busy_cycles_o=3 afterwards.
- FENCE_I with no_st_pending_i low for 5 cycles after acceptance, D$ ack 2 cycles after its request, I$ ack 1 cycle after its request -> order DRAIN(6 cycles), DFLUSH(3), IFLUSH(2), DONE; icache_flush_o never overlaps dcache_flush_o; done_op_o=1.
- SFENCE_VMA with drain already true -> exactly one tlb_flush_o pulse in cycle 2; dcache_flush_o and icache_flush_o stay 0; done_o in cycle 3.
- DRAIN_TIMEOUT=4, FLUSH_DCACHE held with no_st_pending_i=0 for 10 cycles -> timeout_o rises after 4 DRAIN cycles and stays 1 after done_o; a second clean request leaves timeout_o=1.
- halt_i=1 with req_valid_i=1 in IDLE -> req_ready_o=0 and busy_o=0. Raising halt_i mid-DFLUSH still completes with done_o. rst_i pulsed mid-IFLUSH -> all outputs 0 the next cycle and no done_o.
- Stray dcache_flush_ack_i pulses in IDLE/DRAIN -> ignored; DFLUSH still waits for a fresh ack. busy_cycles_o forced near all-ones (CNT_W=4) -> saturates at 15.
